// File: rtl/dmem_arb_pkg.sv
// Shared types and parameter limits for the data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    typedef enum logic {OWN_CPU, OWN_DMA} owner_t;

    localparam int unsigned MEM_LAT_MIN    = 1;
    localparam int unsigned MEM_LAT_MAX    = 4;
    localparam int unsigned STARVE_MAX_MIN = 1;
    localparam int unsigned STARVE_MAX_MAX = 15;

    localparam int unsigned LAT_CNT_W    = $clog2(MEM_LAT_MAX);
    localparam int unsigned STARVE_CNT_W = $clog2(STARVE_MAX_MAX + 1);

endpackage

// File: rtl/dmem_arb_pick.sv
// Fixed-priority picker: CPU wins unless the DMA master has been starved.
module dmem_arb_pick (
    input  logic cpu_req,
    input  logic dma_req,
    input  logic starved,
    output logic grant_dma,
    output logic grant_valid
);

    always_comb begin
        grant_valid = cpu_req | dma_req;
        grant_dma   = dma_req & (~cpu_req | starved);
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter between the CPU MEM stage and a DMA/debug
// master; one outstanding access sequenced through IDLE/ACCESS/RESP.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    if (MEM_LAT < MEM_LAT_MIN || MEM_LAT > MEM_LAT_MAX ||
        STARVE_MAX < STARVE_MAX_MIN || STARVE_MAX > STARVE_MAX_MAX) begin : g_param_check
        $error("dmem_arbiter: MEM_LAT or STARVE_MAX out of legal range");
    end

    state_t                  state;
    owner_t                  owner;
    logic [STARVE_CNT_W-1:0] starve_cnt;
    logic [LAT_CNT_W-1:0]    lat_cnt;
    logic                    starved;
    logic                    grant_dma;
    logic                    grant_valid;

    always_comb begin
        starved   = (starve_cnt == STARVE_CNT_W'(STARVE_MAX));
        cpu_stall = cpu_req & ~((state == RESP) && (owner == OWN_CPU));
    end

    dmem_arb_pick u_pick (
        .cpu_req     (cpu_req),
        .dma_req     (dma_req),
        .starved     (starved),
        .grant_dma   (grant_dma),
        .grant_valid (grant_valid)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            owner      <= OWN_CPU;
            starve_cnt <= '0;
            lat_cnt    <= '0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_rdata  <= '0;
            dma_rdata  <= '0;
            dma_ack    <= 1'b0;
        end else begin
            mem_en  <= 1'b0;
            dma_ack <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (grant_valid) begin
                        state   <= ACCESS;
                        mem_en  <= 1'b1;
                        lat_cnt <= LAT_CNT_W'(MEM_LAT - 1);
                        if (grant_dma) begin
                            owner      <= OWN_DMA;
                            mem_we     <= dma_we;
                            mem_addr   <= dma_addr;
                            mem_wdata  <= dma_wdata;
                            starve_cnt <= '0;
                        end else begin
                            owner     <= OWN_CPU;
                            mem_we    <= cpu_we;
                            mem_addr  <= cpu_addr;
                            mem_wdata <= cpu_wdata;
                            // A CPU win with dma_req high implies not starved, so this never overflows.
                            starve_cnt <= dma_req ? starve_cnt + STARVE_CNT_W'(1) : '0;
                        end
                    end
                end
                ACCESS: begin
                    if (lat_cnt == '0) begin
                        state <= RESP;
                        if (owner == OWN_DMA) begin
                            dma_rdata <= mem_rdata;
                            dma_ack   <= 1'b1;
                        end else begin
                            cpu_rdata <= mem_rdata;
                        end
                    end else begin
                        lat_cnt <= lat_cnt - LAT_CNT_W'(1);
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: three instances with different MEM_LAT/STARVE_MAX.
module tb_dmem_arbiter;

    localparam int LAT_T  [3] = '{1, 3, 2};
    localparam int SMAX_T [3] = '{4, 4, 2};

    typedef struct {
        logic [31:0] rdata;
        int          due;
        bit          chk;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        cpu_req   [3];
    logic        cpu_we    [3];
    logic [31:0] cpu_addr  [3];
    logic [31:0] cpu_wdata [3];
    logic [31:0] cpu_rdata [3];
    logic        cpu_stall [3];
    logic        dma_req   [3];
    logic        dma_we    [3];
    logic [31:0] dma_addr  [3];
    logic [31:0] dma_wdata [3];
    logic [31:0] dma_rdata [3];
    logic        dma_ack   [3];
    logic        mem_en    [3];
    logic        mem_we    [3];
    logic [31:0] mem_addr  [3];
    logic [31:0] mem_wdata [3];
    logic [31:0] mem_rdata [3];

    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_inst
        logic [31:0] mem [64];
        int          age;

        dmem_arbiter #(
            .ADDR_W     (32),
            .DATA_W     (32),
            .MEM_LAT    (LAT_T[g]),
            .STARVE_MAX (SMAX_T[g])
        ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .cpu_req   (cpu_req[g]),
            .cpu_we    (cpu_we[g]),
            .cpu_addr  (cpu_addr[g]),
            .cpu_wdata (cpu_wdata[g]),
            .cpu_rdata (cpu_rdata[g]),
            .cpu_stall (cpu_stall[g]),
            .dma_req   (dma_req[g]),
            .dma_we    (dma_we[g]),
            .dma_addr  (dma_addr[g]),
            .dma_wdata (dma_wdata[g]),
            .dma_rdata (dma_rdata[g]),
            .dma_ack   (dma_ack[g]),
            .mem_en    (mem_en[g]),
            .mem_we    (mem_we[g]),
            .mem_addr  (mem_addr[g]),
            .mem_wdata (mem_wdata[g]),
            .mem_rdata (mem_rdata[g])
        );

        // Memory model: contents reload while reset is low; read data is only
        // valid in the MEM_LAT-th access cycle, garbage otherwise.
        always @(posedge clk) begin
            if (!reset) begin
                for (int j = 0; j < 64; j++) mem[j] <= 32'hA500_0000 | 32'(j);
                mem[4] <= 32'hDEAD_BEEF;
                age    <= 0;
            end else begin
                if (mem_en[g] && mem_we[g]) mem[mem_addr[g][7:2]] <= mem_wdata[g];
                if (mem_en[g]) age <= 2;
                else if (age != 0 && age < 8) age <= age + 1;
            end
        end
        assign mem_rdata[g] = ((mem_en[g] ? 1 : age) == LAT_T[g]) ? mem[mem_addr[g][7:2]] : 32'hBAD0_BAD0;
    end

    task automatic test_reset();
        logic [130:0] v;
        reset = 1'b0;
        cpu_req[0] = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            v = {mem_en[i], mem_we[i], dma_ack[i], mem_addr[i], mem_wdata[i], cpu_rdata[i], dma_rdata[i]};
            vectors++;
            if (v !== '0) begin
                miscompares++;
                $display("FAIL reset_outputs inst%0d: got %h, want 0", i, v);
            end
            vectors++;
            if (cpu_stall[i] !== cpu_req[i]) begin
                miscompares++;
                $display("FAIL reset_stall inst%0d: got %b, want %b", i, cpu_stall[i], cpu_req[i]);
            end
        end
        cpu_req[0] = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic single_access(input int i, input bit is_dma, input bit we,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] exp_rd);
        int          t0;
        int          stall_n = 0;
        int          en_n = 0;
        bit          done = 1'b0;
        bit          resp;
        logic [31:0] rd;
        exp_t        e;
        @(negedge clk);
        if (is_dma) begin
            dma_req[i] = 1'b1; dma_we[i] = we; dma_addr[i] = addr; dma_wdata[i] = wdata;
        end else begin
            cpu_req[i] = 1'b1; cpu_we[i] = we; cpu_addr[i] = addr; cpu_wdata[i] = wdata;
        end
        t0 = cyc;
        sb.push_back('{rdata: exp_rd, due: t0 + LAT_T[i] + 1, chk: !we});
        for (int k = 0; k < 12 && !done; k++) begin
            #1;
            if (cpu_stall[i]) stall_n++;
            if (mem_en[i]) begin
                en_n++;
                vectors++;
                if (mem_addr[i] !== addr || mem_we[i] !== we || (we && mem_wdata[i] !== wdata)) begin
                    miscompares++;
                    $display("FAIL mem_cmd inst%0d: got we=%b addr=%h wdata=%h, want we=%b addr=%h wdata=%h",
                             i, mem_we[i], mem_addr[i], mem_wdata[i], we, addr, wdata);
                end
            end
            resp = is_dma ? dma_ack[i] : (cpu_req[i] & ~cpu_stall[i]);
            if (resp) begin
                e  = sb.pop_front();
                rd = is_dma ? dma_rdata[i] : cpu_rdata[i];
                vectors++;
                if (cyc != e.due) begin
                    miscompares++;
                    $display("FAIL resp_cycle inst%0d: got %0d, want %0d", i, cyc, e.due);
                end
                if (e.chk) begin
                    vectors++;
                    if (rd !== e.rdata) begin
                        miscompares++;
                        $display("FAIL rdata inst%0d: got %h, want %h", i, rd, e.rdata);
                    end
                end
                done = 1'b1;
            end
            @(negedge clk);
        end
        cpu_req[i] = 1'b0;
        dma_req[i] = 1'b0;
        if (!done) begin
            void'(sb.pop_front());
            miscompares++;
            $display("FAIL resp_timeout inst%0d: got no response, want one", i);
        end
        vectors++;
        if (en_n != 1) begin
            miscompares++;
            $display("FAIL mem_en_pulses inst%0d: got %0d, want 1", i, en_n);
        end
        vectors++;
        if (stall_n != (is_dma ? 0 : LAT_T[i] + 1)) begin
            miscompares++;
            $display("FAIL stall_cycles inst%0d: got %0d, want %0d", i, stall_n, is_dma ? 0 : LAT_T[i] + 1);
        end
        if (is_dma) begin
            #1;
            vectors++;
            if (dma_ack[i] !== 1'b0) begin
                miscompares++;
                $display("FAIL ack_width inst%0d: got %b, want 0", i, dma_ack[i]);
            end
        end
    endtask

    task automatic test_cpu_read();
        single_access(0, 1'b0, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF);
    endtask

    task automatic test_dma_write_read();
        single_access(1, 1'b1, 1'b1, 32'h20, 32'h55, 32'h0);
        single_access(1, 1'b1, 1'b0, 32'h20, 32'h0, 32'h55);
    endtask

    task automatic test_simultaneous();
        logic [31:0] gq[$];
        logic [31:0] want;
        int          n = 0;
        int          acks = 0;
        int          first = 0;
        gq = {32'h10, 32'h20};
        @(negedge clk);
        cpu_req[0] = 1'b1; cpu_we[0] = 1'b0; cpu_addr[0] = 32'h10;
        dma_req[0] = 1'b1; dma_we[0] = 1'b0; dma_addr[0] = 32'h20;
        for (int k = 0; k < 16 && (n < 2 || acks == 0); k++) begin
            #1;
            if (mem_en[0]) begin
                n++;
                vectors++;
                if (gq.size() == 0) begin
                    miscompares++;
                    $display("FAIL simul_extra_grant: got addr %h, want none", mem_addr[0]);
                end else begin
                    want = gq.pop_front();
                    if (mem_addr[0] !== want) begin
                        miscompares++;
                        $display("FAIL simul_grant%0d: got addr %h, want %h", n, mem_addr[0], want);
                    end
                end
                if (n == 1) begin
                    first = cyc;
                    cpu_req[0] = 1'b0;
                end else begin
                    vectors++;
                    if (cyc - first != LAT_T[0] + 2) begin
                        miscompares++;
                        $display("FAIL simul_spacing: got %0d, want %0d", cyc - first, LAT_T[0] + 2);
                    end
                    dma_req[0] = 1'b0;
                end
            end
            if (dma_ack[0]) acks++;
            @(negedge clk);
        end
        cpu_req[0] = 1'b0;
        dma_req[0] = 1'b0;
        vectors++;
        if (gq.size() != 0 || acks != 1) begin
            miscompares++;
            $display("FAIL simul_complete: got %0d grants left, %0d acks, want 0 left, 1 ack", gq.size(), acks);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_dma_drop();
        int   t0;
        int   acks = 0;
        int   ens = 0;
        exp_t e;
        @(negedge clk);
        dma_req[0] = 1'b1; dma_we[0] = 1'b0; dma_addr[0] = 32'h24;
        t0 = cyc;
        sb.push_back('{rdata: 32'hA500_0009, due: t0 + LAT_T[0] + 1, chk: 1'b1});
        @(negedge clk);
        dma_req[0] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            #1;
            if (mem_en[0]) ens++;
            if (dma_ack[0]) begin
                acks++;
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    vectors++;
                    if (cyc != e.due || dma_rdata[0] !== e.rdata) begin
                        miscompares++;
                        $display("FAIL drop_resp: got cycle %0d data %h, want cycle %0d data %h",
                                 cyc, dma_rdata[0], e.due, e.rdata);
                    end
                end
            end
            @(negedge clk);
        end
        if (sb.size() != 0) void'(sb.pop_front());
        vectors++;
        if (acks != 1 || ens != 1) begin
            miscompares++;
            $display("FAIL drop_counts: got %0d acks %0d mem_en, want 1 and 1", acks, ens);
        end
        single_access(0, 1'b0, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF);
    endtask

    task automatic test_starvation();
        logic [31:0] gq[$];
        logic [31:0] want;
        int          last = -1;
        int          n = 0;
        gq = {32'h10, 32'h10, 32'h20, 32'h10, 32'h10, 32'h20};
        @(negedge clk);
        cpu_req[2] = 1'b1; cpu_we[2] = 1'b0; cpu_addr[2] = 32'h10;
        dma_req[2] = 1'b1; dma_we[2] = 1'b0; dma_addr[2] = 32'h20;
        for (int k = 0; k < 40 && gq.size() != 0; k++) begin
            #1;
            if (mem_en[2]) begin
                want = gq.pop_front();
                vectors++;
                if (mem_addr[2] !== want) begin
                    miscompares++;
                    $display("FAIL grant_order%0d: got addr %h, want %h", n, mem_addr[2], want);
                end
                if (last >= 0) begin
                    vectors++;
                    if (cyc - last != LAT_T[2] + 2) begin
                        miscompares++;
                        $display("FAIL grant_spacing%0d: got %0d, want %0d", n, cyc - last, LAT_T[2] + 2);
                    end
                end
                last = cyc;
                n++;
            end
            @(negedge clk);
        end
        cpu_req[2] = 1'b0;
        dma_req[2] = 1'b0;
        vectors++;
        if (gq.size() != 0) begin
            miscompares++;
            $display("FAIL starve_timeout: got %0d grants, want 6", n);
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [130:0] v;
        int           bad = 0;
        @(negedge clk);
        cpu_req[2] = 1'b1; cpu_we[2] = 1'b0; cpu_addr[2] = 32'h10;
        repeat (2) @(negedge clk);
        #1;
        vectors++;
        if (mem_addr[2] !== 32'h10 || cpu_stall[2] !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_precond: got addr %h stall %b, want 00000010 1", mem_addr[2], cpu_stall[2]);
        end
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            v = {mem_en[2], mem_we[2], dma_ack[2], mem_addr[2], mem_wdata[2], cpu_rdata[2], dma_rdata[2]};
            vectors++;
            if (v !== '0 || cpu_stall[2] !== cpu_req[2]) begin
                miscompares++;
                $display("FAIL mid_reset_outputs%0d: got %h stall %b, want 0 stall %b", k, v, cpu_stall[2], cpu_req[2]);
            end
            cpu_req[2] = 1'b0;
            @(negedge clk);
        end
        reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            if (dma_ack[2] || mem_en[2] || cpu_rdata[2] !== '0) bad++;
            @(negedge clk);
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL mid_no_ack: got %0d active cycles, want 0", bad);
        end
        single_access(2, 1'b0, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF);
    endtask

    initial begin
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cpu_req[i] = 1'b0; cpu_we[i] = 1'b0; cpu_addr[i] = '0; cpu_wdata[i] = '0;
            dma_req[i] = 1'b0; dma_we[i] = 1'b0; dma_addr[i] = '0; dma_wdata[i] = '0;
        end
        test_reset();
        test_cpu_read();
        test_dma_write_read();
        test_simultaneous();
        test_dma_drop();
        test_starvation();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got time limit, want normal finish");
        $fatal(1, "watchdog expired");
    end

endmodule
